// File: rtl/axi_lite_ram_slave.sv
// AXI4-Lite style word RAM responder with byte write strobes.
// Read and write channels run concurrently; reads have a configurable extra latency.
module axi_lite_ram_slave #(
    parameter int ADDR_BITS    = 10,
    parameter int READ_LATENCY = 0
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        ARvalid,
    output logic        ARready,
    input  logic [31:0] ARdata,
    input  logic [2:0]  arprot,
    output logic        Rvalid,
    input  logic        RReady,
    output logic [31:0] Rdata,
    input  logic        AWvalid,
    output logic        AWready,
    input  logic [31:0] AWdata,
    input  logic [2:0]  awprot,
    input  logic        Wvalid,
    output logic        Wready,
    input  logic [31:0] Wdata,
    input  logic [3:0]  Wstrb,
    output logic        Bvalid,
    input  logic        Bready
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [3:0] WAIT_INIT = 4'(READ_LATENCY > 0 ? READ_LATENCY - 1 : 0);

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;

    logic [31:0] mem [DEPTH];

    r_state_t             r_state;
    r_state_t             r_next;
    logic [3:0]           r_count;
    logic [ADDR_BITS-1:0] r_index;
    logic [ADDR_BITS-1:0] ar_index;
    logic [ADDR_BITS-1:0] rd_index;
    logic                 ar_hs;

    logic                 aw_held;
    logic                 w_held;
    logic [ADDR_BITS-1:0] aw_index_q;
    logic [31:0]          w_data_q;
    logic [3:0]           w_strb_q;
    logic                 aw_hs;
    logic                 w_hs;
    logic                 commit;
    logic [ADDR_BITS-1:0] wr_index;
    logic [31:0]          wr_data;
    logic [3:0]           wr_strb;

    logic unused_bits;
    assign unused_bits = ^{arprot, awprot, ARdata[31:ADDR_BITS+2], ARdata[1:0],
                           AWdata[31:ADDR_BITS+2], AWdata[1:0]};

    assign ar_index = ARdata[ADDR_BITS+1:2];
    assign ar_hs    = ARvalid & ARready;
    // With zero latency the RAM is read on the AR handshake edge itself.
    assign rd_index = (r_state == R_IDLE) ? ar_index : r_index;

    always_comb begin
        r_next  = r_state;
        ARready = 1'b0;
        Rvalid  = 1'b0;
        case (r_state)
            R_IDLE: begin
                ARready = resetn;
                if (ARvalid && resetn)
                    r_next = (READ_LATENCY > 0) ? R_WAIT : R_DATA;
            end
            R_WAIT: begin
                if (r_count == 4'd0)
                    r_next = R_DATA;
            end
            R_DATA: begin
                Rvalid = 1'b1;
                if (RReady)
                    r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn)
            r_state <= R_IDLE;
        else
            r_state <= r_next;
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            Rdata   <= 32'd0;
            r_count <= 4'd0;
            r_index <= '0;
        end else begin
            if (ar_hs) begin
                r_index <= ar_index;
                r_count <= WAIT_INIT;
            end else if (r_state == R_WAIT && r_count != 4'd0) begin
                r_count <= r_count - 4'd1;
            end
            if (r_next == R_DATA && r_state != R_DATA)
                Rdata <= mem[rd_index];
        end
    end

    assign AWready = resetn & ~aw_held & ~Bvalid;
    assign Wready  = resetn & ~w_held & ~Bvalid;
    assign aw_hs   = AWvalid & AWready;
    assign w_hs    = Wvalid & Wready;
    assign commit  = resetn & (aw_held | aw_hs) & (w_held | w_hs) & ~Bvalid;

    // A handshake on the commit edge supplies its values directly.
    assign wr_index = aw_held ? aw_index_q : AWdata[ADDR_BITS+1:2];
    assign wr_data  = w_held ? w_data_q : Wdata;
    assign wr_strb  = w_held ? w_strb_q : Wstrb;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            aw_held    <= 1'b0;
            w_held     <= 1'b0;
            Bvalid     <= 1'b0;
            aw_index_q <= '0;
            w_data_q   <= 32'd0;
            w_strb_q   <= 4'd0;
        end else begin
            if (aw_hs)
                aw_index_q <= AWdata[ADDR_BITS+1:2];
            if (w_hs) begin
                w_data_q <= Wdata;
                w_strb_q <= Wstrb;
            end
            if (commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                Bvalid  <= 1'b1;
            end else begin
                if (aw_hs)
                    aw_held <= 1'b1;
                if (w_hs)
                    w_held <= 1'b1;
                if (Bvalid && Bready)
                    Bvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < 4; i++) begin
            if (commit && wr_strb[i])
                mem[wr_index][8*i +: 8] <= wr_data[8*i +: 8];
        end
    end

endmodule

// File: tb/tb_axi_lite_ram_slave.sv
// Bench for axi_lite_ram_slave: directed channel-timing steps plus randomized
// traffic compared against a word-array model of the memory.
module tb_axi_lite_ram_slave;

    localparam int DEPTH = 1024;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        resetn;
    logic        ARvalid, ARready, Rvalid, RReady, AWvalid, AWready, Wvalid, Wready, Bvalid, Bready;
    logic [31:0] ARdata, Rdata, AWdata, Wdata;
    logic [2:0]  arprot, awprot;
    logic [3:0]  Wstrb;

    logic        l2_ARvalid, l2_ARready, l2_Rvalid, l2_RReady, l2_AWvalid, l2_AWready;
    logic        l2_Wvalid, l2_Wready, l2_Bvalid, l2_Bready;
    logic [31:0] l2_ARdata, l2_Rdata, l2_AWdata, l2_Wdata;
    logic [3:0]  l2_Wstrb;

    int checks = 0;
    int fails  = 0;
    logic [31:0] ref_mem [int];

    axi_lite_ram_slave #(.ADDR_BITS(10), .READ_LATENCY(0)) dut (
        .clock(clock), .resetn(resetn),
        .ARvalid(ARvalid), .ARready(ARready), .ARdata(ARdata), .arprot(arprot),
        .Rvalid(Rvalid), .RReady(RReady), .Rdata(Rdata),
        .AWvalid(AWvalid), .AWready(AWready), .AWdata(AWdata), .awprot(awprot),
        .Wvalid(Wvalid), .Wready(Wready), .Wdata(Wdata), .Wstrb(Wstrb),
        .Bvalid(Bvalid), .Bready(Bready)
    );

    axi_lite_ram_slave #(.ADDR_BITS(10), .READ_LATENCY(2)) dut_l2 (
        .clock(clock), .resetn(resetn),
        .ARvalid(l2_ARvalid), .ARready(l2_ARready), .ARdata(l2_ARdata), .arprot(arprot),
        .Rvalid(l2_Rvalid), .RReady(l2_RReady), .Rdata(l2_Rdata),
        .AWvalid(l2_AWvalid), .AWready(l2_AWready), .AWdata(l2_AWdata), .awprot(awprot),
        .Wvalid(l2_Wvalid), .Wready(l2_Wready), .Wdata(l2_Wdata), .Wstrb(l2_Wstrb),
        .Bvalid(l2_Bvalid), .Bready(l2_Bready)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            fails++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic int word_of(input logic [31:0] addr);
        return int'((addr >> 2) % DEPTH);
    endfunction

    function automatic void model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        logic [31:0] mask = 32'd0;
        int idx = word_of(addr);
        for (int i = 0; i < 4; i++)
            if (strb[i]) mask = mask | (32'hFF << (8 * i));
        if (!ref_mem.exists(idx)) ref_mem[idx] = 'x;
        ref_mem[idx] = (ref_mem[idx] & ~mask) | (data & mask);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        int idx = word_of(addr);
        if (!ref_mem.exists(idx)) return 'x;
        return ref_mem[idx];
    endfunction

    task automatic applyStimulus(input logic arv, input logic [31:0] araddr, input logic rready,
                                 input logic awv, input logic [31:0] awaddr,
                                 input logic wv, input logic [31:0] wdata, input logic [3:0] wstrb,
                                 input logic bready);
        ARvalid = arv;  ARdata = araddr;  RReady = rready;
        AWvalid = awv;  AWdata = awaddr;
        Wvalid  = wv;   Wdata  = wdata;   Wstrb  = wstrb;
        Bready  = bready;
    endtask

    // Combined AW+W write: Bvalid must appear one cycle later and clear after Bready.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, addr, 1'b1, data, strb, 1'b1);
        checkOutput("wr_ready_pre", {AWready, Wready}, 2'b11);
        tick();
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 4'd0, 1'b1);
        checkOutput("wr_bvalid", Bvalid, 1'b1);
        model_write(addr, data, strb);
        tick();
        checkOutput("wr_bclear", Bvalid, 1'b0);
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] data);
        applyStimulus(1'b1, addr, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 4'd0, 1'b1);
        checkOutput("rd_arready_pre", ARready, 1'b1);
        tick();
        ARvalid = 1'b0;
        checkOutput("rd_rvalid", Rvalid, 1'b1);
        data = Rdata;
        tick();
        checkOutput("rd_rclear", Rvalid, 1'b0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired before summary");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] old_word;
        logic [31:0] addr;

        arprot = 3'($urandom);
        awprot = 3'($urandom);
        l2_ARvalid = 0; l2_ARdata = 0; l2_RReady = 0; l2_AWvalid = 0; l2_AWdata = 0;
        l2_Wvalid = 0;  l2_Wdata = 0;  l2_Wstrb = 0;  l2_Bready = 0;

        // Reset with all valids asserted: nothing may be accepted.
        resetn = 1'b0;
        applyStimulus(1'b1, 32'h10, 1'b0, 1'b1, 32'h10, 1'b1, 32'h12345678, 4'hF, 1'b0);
        repeat (3) tick();
        checkOutput("rst_readies", {ARready, AWready, Wready}, 3'b000);
        checkOutput("rst_valids", {Rvalid, Bvalid}, 2'b00);
        checkOutput("rst_rdata", Rdata, 32'd0);
        checkOutput("rst_l2_valids", {l2_Rvalid, l2_Bvalid, l2_ARready}, 3'b000);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 4'd0, 1'b0);
        resetn = 1'b1;
        #1;
        checkOutput("post_rst_readies", {ARready, AWready, Wready}, 3'b111);

        for (int i = 0; i < 16; i++)
            do_write(32'(i * 4), $urandom, 4'hF);

        // Full word write then read.
        do_write(32'h10, 32'hDEADBEEF, 4'hF);
        do_read(32'h10, rd);
        checkOutput("full_word", rd, 32'hDEADBEEF);

        // Byte and half-word strobes.
        do_write(32'h10, 32'h000000AA, 4'b0001);
        do_write(32'h10, 32'h12340000, 4'b1100);
        do_read(32'h10, rd);
        checkOutput("strobe_merge", rd, 32'h1234BEAA);

        // Empty strobe still completes but changes nothing.
        do_write(32'h10, 32'hFFFFFFFF, 4'b0000);
        do_read(32'h10, rd);
        checkOutput("strobe_none", rd, 32'h1234BEAA);

        // Split channels: W first, AW three cycles later, response back-pressured.
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1, 32'hA5A50F0F, 4'hF, 1'b0);
        tick();
        Wvalid = 1'b0;
        checkOutput("split_w_held", {Wready, AWready, Bvalid}, 3'b010);
        tick();
        tick();
        checkOutput("split_no_b_yet", Bvalid, 1'b0);
        AWvalid = 1'b1;
        AWdata  = 32'h20;
        tick();
        checkOutput("split_bvalid", Bvalid, 1'b1);
        model_write(32'h20, 32'hA5A50F0F, 4'hF);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 32'h24, 1'b1, 32'hFFFFFFFF, 4'hF, 1'b0);
        tick();
        tick();
        checkOutput("split_b_hold", {Bvalid, AWready, Wready}, 3'b100);
        Bready = 1'b1;
        tick();
        checkOutput("split_b_clear", Bvalid, 1'b0);
        AWvalid = 1'b0;
        Wvalid  = 1'b0;
        checkOutput("split_ready_back", {AWready, Wready}, 2'b11);
        do_read(32'h20, rd);
        checkOutput("split_data", rd, model_read(32'h20));
        do_read(32'h24, rd);
        checkOutput("split_no_intruder", rd, model_read(32'h24));

        // Address wrap modulo 4 KiB.
        do_write(32'h1000, 32'h00000055, 4'hF);
        do_read(32'h0000, rd);
        checkOutput("wrap_alias", rd, 32'h00000055);

        // Read and write of the same word on the same edge: read sees old data.
        old_word = model_read(32'h30);
        applyStimulus(1'b1, 32'h30, 1'b1, 1'b1, 32'h30, 1'b1, 32'h77777777, 4'hF, 1'b1);
        tick();
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 4'd0, 1'b1);
        checkOutput("collide_valids", {Rvalid, Bvalid}, 2'b11);
        checkOutput("collide_old", Rdata, old_word);
        model_write(32'h30, 32'h77777777, 4'hF);
        tick();
        do_read(32'h30, rd);
        checkOutput("collide_new", rd, 32'h77777777);

        // Randomized traffic with aliased upper bits and ignored low bits.
        for (int n = 0; n < 60; n++) begin
            addr = ($urandom & 32'hFFFFF000) | (32'($urandom_range(0, 15)) << 2) | ($urandom & 32'h3);
            if ($urandom_range(0, 1) == 1) begin
                do_write(addr, $urandom, 4'($urandom));
            end else begin
                do_read(addr, rd);
                checkOutput("rand_read", rd, model_read(addr));
            end
        end

        // Latency-2 instance with read back-pressure.
        l2_AWvalid = 1'b1; l2_AWdata = 32'h40; l2_Wvalid = 1'b1;
        l2_Wdata = 32'hCAFEF00D; l2_Wstrb = 4'hF; l2_Bready = 1'b1;
        tick();
        l2_AWvalid = 1'b0; l2_Wvalid = 1'b0;
        checkOutput("l2_bvalid", l2_Bvalid, 1'b1);
        tick();
        l2_ARvalid = 1'b1; l2_ARdata = 32'h40; l2_RReady = 1'b0;
        tick();
        l2_ARvalid = 1'b0;
        checkOutput("l2_c1", {l2_ARready, l2_Rvalid}, 2'b00);
        tick();
        checkOutput("l2_c2", {l2_ARready, l2_Rvalid}, 2'b00);
        tick();
        checkOutput("l2_c3_valid", {l2_ARready, l2_Rvalid}, 2'b01);
        checkOutput("l2_c3_data", l2_Rdata, 32'hCAFEF00D);
        tick();
        tick();
        checkOutput("l2_c5_hold", {l2_ARready, l2_Rvalid}, 2'b01);
        checkOutput("l2_c5_data", l2_Rdata, 32'hCAFEF00D);
        tick();
        l2_RReady = 1'b1;
        checkOutput("l2_c6_hold", {l2_ARready, l2_Rvalid}, 2'b01);
        tick();
        checkOutput("l2_c7_release", {l2_ARready, l2_Rvalid}, 2'b10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end

endmodule
